// File: rtl/switch_pulse_pkg.sv
// Shared types and decode for the switch pulse generator: FSM states, code type,
// code constants and the 2-bit code to one-hot switch line mapping.
package switch_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Code is {x,y} where x = SW3|SW2 and y = SW3|SW1
    typedef logic [1:0] code_t;

    localparam code_t CODE_SW0 = 2'b00;
    localparam code_t CODE_SW1 = 2'b01;
    localparam code_t CODE_SW2 = 2'b10;
    localparam code_t CODE_SW3 = 2'b11;

    function automatic logic [3:0] code_to_onehot(input code_t c);
        logic [3:0] oh;
        oh = 4'b0000;
        case (c)
            CODE_SW0: oh = 4'b0001;
            CODE_SW1: oh = 4'b0010;
            CODE_SW2: oh = 4'b0100;
            CODE_SW3: oh = 4'b1000;
            default:  oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// Generic synchronous FIFO, DEPTH x WIDTH, power-of-2 depth, show-ahead read.
// Latency: a push is visible on dout/empty the cycle after the write edge.
// Backpressure: push ignored while full, pop ignored while empty; full is not relieved by a same-cycle pop.
module code_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: empty gates every read of it
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/switch_pulse_generator.sv
// Turns queued 2-bit codes into one-hot switch pulses: HOLD_CYCLES high, then GAP_CYCLES all-low.
// Latency: code accepted at edge t drives LINES from edge t+1 when idle; back-to-back period HOLD+GAP.
// Backpressure: code_ready drops while the FIFO_DEPTH-entry code queue is full; codes are never dropped.
module switch_pulse_generator
    import switch_pulse_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic       code_valid,
    input  logic [1:0] code,
    output logic       code_ready,
    output logic [3:0] LINES,
    output logic       pulse,
    output logic       busy
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    lines_n;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    code_t         fifo_dout;

    code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_code_fifo (
        .clk   (CLOCK_50),
        .rst_n (RST_N),
        .push  (code_valid),
        .pop   (fifo_pop),
        .din   (code),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign code_ready = !fifo_full;
    assign pulse      = |LINES;
    assign busy       = !fifo_empty || (state != IDLE);

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            LINES <= 4'b0000;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            LINES <= lines_n;
        end
    end

    // GAP goes straight to HOLD when work is queued so back-to-back pulses skip IDLE
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        lines_n  = LINES;
        fifo_pop = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    lines_n  = code_to_onehot(fifo_dout);
                    cnt_n    = HOLD_LOAD;
                    state_n  = HOLD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    lines_n = 4'b0000;
                    cnt_n   = GAP_LOAD;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        lines_n  = code_to_onehot(fifo_dout);
                        cnt_n    = HOLD_LOAD;
                        state_n  = HOLD;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                lines_n = 4'b0000;
            end
        endcase
    end

endmodule

// File: tb/tb_switch_pulse_generator.sv
// Directed bench for switch_pulse_generator with HOLD=4, GAP=2, DEPTH=4.
module tb_switch_pulse_generator;

    localparam int H = 4;
    localparam int G = 2;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       code_valid;
    logic [1:0] code;
    logic       code_ready;
    logic [3:0] lines;
    logic       pulse;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] prev_lines;
    logic [1:0] seq [6];
    int         sent;
    int         last_accept_edge;
    int         zero_run;
    logic [3:0] el;
    logic       eb;
    logic       er;

    switch_pulse_generator #(
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .FIFO_DEPTH  (D)
    ) dut (
        .CLOCK_50   (clk),
        .RST_N      (rst_n),
        .code_valid (code_valid),
        .code       (code),
        .code_ready (code_ready),
        .LINES      (lines),
        .pulse      (pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        logic [3:0] r;
        r = 4'b0000;
        case (c)
            2'b00: r = 4'b0001;
            2'b01: r = 4'b0010;
            2'b10: r = 4'b0100;
            2'b11: r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] exp_lines, input logic exp_busy);
        chk({tag, ".lines"}, 8'(lines), 8'(exp_lines));
        chk({tag, ".pulse"}, 8'(pulse), 8'(|exp_lines));
        chk({tag, ".busy"},  8'(busy),  8'(exp_busy));
    endtask

    // Advance one edge, then apply the glitch-free properties to the new LINES value
    task automatic tick();
        @(posedge clk);
        #1;
        chk("onehot0", 8'($countones(lines) <= 1), 8'd1);
        if (prev_lines != 4'b0000 && lines != 4'b0000) begin
            chk("no_direct_change", 8'(lines), 8'(prev_lines));
        end
        prev_lines = lines;
    endtask

    initial begin
        seq        = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11};
        rst_n      = 1'b0;
        code_valid = 1'b0;
        code       = 2'b00;
        prev_lines = 4'b0000;

        // Reset values, held and after release with no codes
        #2;
        chk_out("reset_async", 4'b0000, 1'b0);
        chk("reset_ready", 8'(code_ready), 8'd1);
        repeat (3) tick();
        chk_out("reset_held", 4'b0000, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("idle_after_reset", 4'b0000, 1'b0);
            chk("idle_ready", 8'(code_ready), 8'd1);
        end

        // Single code 10
        code       = 2'b10;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        chk_out("single.accept", 4'b0000, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            el = (k <= 4) ? 4'b0100 : 4'b0000;
            eb = (k < 7);
            chk_out("single", el, eb);
        end

        // All four codes back-to-back
        for (int e = 0; e <= 25; e++) begin
            code_valid = (e < 4);
            code       = 2'(e);
            if (e < 4) chk("b2b.ready", 8'(code_ready), 8'd1);
            tick();
            if (e == 0) begin
                chk_out("b2b.accept", 4'b0000, 1'b1);
            end else begin
                el = ((e - 1) < 24 && ((e - 1) % 6) < 4) ? onehot(2'((e - 1) / 6)) : 4'b0000;
                eb = ((e - 1) < 24);
                chk_out("b2b", el, eb);
            end
        end
        code_valid = 1'b0;

        // Queue full: six codes offered continuously
        sent             = 0;
        last_accept_edge = -1;
        for (int e = 0; e <= 37; e++) begin
            code_valid = (sent < 6);
            code       = (sent < 6) ? seq[sent] : 2'b00;
            er = !((e >= 5 && e <= 7) || (e >= 9 && e <= 13));
            chk("full.ready", 8'(code_ready), 8'(er));
            if (code_valid && code_ready) begin
                sent++;
                last_accept_edge = e;
            end
            tick();
            if (e == 0) begin
                chk_out("full.accept", 4'b0000, 1'b1);
            end else begin
                el = ((e - 1) < 36 && ((e - 1) % 6) < 4) ? onehot(seq[(e - 1) / 6]) : 4'b0000;
                eb = ((e - 1) < 36);
                chk_out("full", el, eb);
            end
        end
        code_valid = 1'b0;
        chk("full.sent", 8'(sent), 8'd6);
        chk("full.sixth_edge", 8'(last_accept_edge), 8'd8);

        // Reset during the 2nd HOLD cycle of the second pulse with three codes queued
        for (int e = 0; e <= 8; e++) begin
            code_valid = (e < 5);
            code       = (e < 5) ? seq[e] : 2'b00;
            tick();
        end
        code_valid = 1'b0;
        chk_out("midrst.hold2", onehot(seq[1]), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("midrst.async", 4'b0000, 1'b0);
        chk("midrst.ready", 8'(code_ready), 8'd1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_out("midrst.after", 4'b0000, 1'b0);
        end

        // Idle start versus back-to-back
        code       = 2'b11;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        chk_out("idle.first_accept", 4'b0000, 1'b1);
        zero_run = 0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            el = (k <= 4) ? 4'b1000 : 4'b0000;
            eb = (k < 7);
            chk_out("idle.first", el, eb);
            if (lines == 4'b0000) zero_run++;
        end
        code       = 2'b01;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        chk_out("idle.second_accept", 4'b0000, 1'b1);
        if (lines == 4'b0000) zero_run++;
        tick();
        chk_out("idle.second_start", 4'b0010, 1'b1);
        chk("idle.gap_len", 8'(zero_run), 8'd14);
        chk("idle.gap_gt", 8'(zero_run > G), 8'd1);
        repeat (6) tick();
        chk_out("idle.done", 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
